hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Parametrised load-use hazard and pipeline-stall controller for the in-order RISC-V pipeline. It sits beside the IF/ID and ID/EX registers and drives PC write-enable, IF/ID write-enable, the ID/EX bubble mux and the IF/ID flush. Relative to the single-cycle load-use detector, it adds configurable register-address width, a load-latency scoreboard for multi-cycle loads, branch flush, memory-busy freeze, an explicit stall FSM and optional performance counters.

Parameters:
REG_AW, 5, register address width; address 0 is hardwired zero and never hazards
LOAD_LAT, 1, cycles after EX before load data is forwardable; 1 = classic single-bubble load-use; range 1..4
CNT_W, 16, performance-counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ifid_rs1  in  REG_AW  source register 1 of the instruction in ID
ifid_rs2  in  REG_AW  source register 2 of the instruction in ID
ifid_rs1_used  in  1  instruction in ID actually reads rs1
ifid_rs2_used  in  1  instruction in ID actually reads rs2
idex_rd  in  REG_AW  destination register of the instruction in EX
idex_memread  in  1  instruction in EX is a load
idex_regwrite  in  1  instruction in EX writes rd
branch_taken  in  1  taken branch/jump resolved in EX this cycle
mem_busy  in  1  data memory not ready; whole pipeline must hold
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID register load enable
idex_bubble  out  1  force ID/EX control fields to NOP
ifid_flush  out  1  clear IF/ID to NOP
stall  out  1  load-use stall active this cycle
freeze  out  1  pipeline frozen by mem_busy
state  out  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 FREEZE
stall_cycles  out  CNT_W  perf counter (see Optional Feature)
freeze_cycles  out  CNT_W  perf counter (see Optional Feature)
flush_count  out  CNT_W  perf counter (see Optional Feature)

Behaviour:
- One clock; reset is synchronous and active-high. While reset=1 and on the first cycle after: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, stall=0, freeze=0, state=RUN, scoreboard cleared, counters 0. Reset mid-stall abandons the stall and clears pending scoreboard entries.
- Scoreboard: LOAD_LAT-1 entries {valid, rd}; empty when LOAD_LAT=1. On every cycle with mem_busy=0: entry0 <= {idex_memread & idex_regwrite & (idex_rd!=0), idex_rd}; entry k <= entry k-1; the oldest entry drops out. If mem_busy=1, the scoreboard holds.
- Match(r) = r!=0 and ((idex_memread & idex_regwrite & idex_rd==r) or any valid entry with rd==r).
- hazard = (ifid_rs1_used & Match(ifid_rs1)) | (ifid_rs2_used & Match(ifid_rs2)).
- Control outputs are combinational from the current inputs and scoreboard (zero latency). Priority is mem_busy > branch_taken > hazard:
  - mem_busy=1: freeze=1, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0, stall=0. A branch_taken seen during freeze is ignored; EX holds, so it is re-presented after the freeze.
  - branch_taken=1: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1, stall=0. The ID instruction is squashed, so a hazard is irrelevant.
  - hazard=1: stall=1, pc_write=0, ifid_write=0, idex_bubble=1.
  - otherwise: pc_write=1, ifid_write=1, all other outputs 0.
- FSM (registered): next state = FREEZE if mem_busy, else LOAD_STALL if stall, else RUN. This is status only and adds no latency.
- Stall length: a load in EX followed by a dependent instruction in ID stalls exactly LOAD_LAT cycles, because bubbles advance the load through the scoreboard.
- Equal rs1/rs2 produces one match, not two.

Optional Feature:
HAZARD_PERF_CNT_EN defined: stall_cycles increments on each cycle with stall=1, freeze_cycles on each cycle with freeze=1, and flush_count on each cycle with ifid_flush=1. All three counters saturate at 2^CNT_W-1 and clear on reset.
HAZARD_PERF_CNT_EN undefined: all three outputs are constant 0 and no counter flops exist.

Test Plan:
- LOAD_LAT=1: EX lw x5 (memread=1, regwrite=1, rd=5), ID rs1=5 used -> stall=1, pc_write=0, idex_bubble=1 for exactly 1 cycle, then RUN.
- LOAD_LAT=3: load rd=7, dependent rs2=7 in the next ID -> stall held 3 consecutive cycles; stall_cycles=3 with HAZARD_PERF_CNT_EN.
- rd=0 load, or rs1=5 with ifid_rs1_used=0 -> no stall; also idex_regwrite=0 -> no stall.
- Hazard and branch_taken in the same cycle -> ifid_flush=1, idex_bubble=1, stall=0, pc_write=1; flush_count increments by 1.
- mem_busy=1 for 4 cycles during a LOAD_LAT=2 stall -> freeze=1, all enables 0, scoreboard held; after release the remaining stall cycle completes and freeze_cycles=4.
- Assert reset mid-stall (LOAD_LAT=3, second stall cycle) -> next cycle state=RUN, stall=0, scoreboard empty, counters 0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-side signal bundle for hazard_stall_ctrl
// master = pipeline/datapath side, slave = the stall controller.
interface hazard_stall_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] ifid_rs1;
  logic [REG_AW-1:0] ifid_rs2;
  logic              ifid_rs1_used;
  logic              ifid_rs2_used;
  logic [REG_AW-1:0] idex_rd;
  logic              idex_memread;
  logic              idex_regwrite;
  logic              branch_taken;
  logic              mem_busy;
  logic              pc_write;
  logic              ifid_write;
  logic              idex_bubble;
  logic              ifid_flush;
  logic              stall;
  logic              freeze;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  freeze_cycles;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
           idex_rd, idex_memread, idex_regwrite, branch_taken, mem_busy,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, stall, freeze,
           state, stall_cycles, freeze_cycles, flush_count
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
           idex_rd, idex_memread, idex_regwrite, branch_taken, mem_busy,
    output pc_write, ifid_write, idex_bubble, ifid_flush, stall, freeze,
           state, stall_cycles, freeze_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use hazard / stall / flush / freeze controller with load-latency scoreboard
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  hazard_stall_ctrl_if.slave hz
);
  localparam int SB_D = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FREEZE     = 2'd2
  } state_e;

  state_e            state_q;
  logic [SB_D-1:0]   sb_v_q;
  logic [REG_AW-1:0] sb_rd_q [SB_D];
  logic              ld_ex;
  logic              m1, m2, hazard;

  assign ld_ex = hz.idex_memread & hz.idex_regwrite & (hz.idex_rd != '0);

  // Older loads still in flight sit in the scoreboard; it advances only when memory is ready.
  generate
    if (LOAD_LAT > 1) begin : g_sb
      always_ff @(posedge clk) begin
        if (reset) begin
          sb_v_q <= '0;
          for (int k = 0; k < SB_D; k++) sb_rd_q[k] <= '0;
        end else if (!hz.mem_busy) begin
          sb_v_q[0]  <= ld_ex;
          sb_rd_q[0] <= hz.idex_rd;
          for (int k = 1; k < SB_D; k++) begin
            sb_v_q[k]  <= sb_v_q[k-1];
            sb_rd_q[k] <= sb_rd_q[k-1];
          end
        end
      end
    end else begin : g_no_sb
      assign sb_v_q = '0;
      assign sb_rd_q[0] = '0;
    end
  endgenerate

  always_comb begin
    m1 = ld_ex && (hz.idex_rd == hz.ifid_rs1);
    m2 = ld_ex && (hz.idex_rd == hz.ifid_rs2);
    for (int k = 0; k < SB_D; k++) begin
      m1 = m1 | (sb_v_q[k] && (sb_rd_q[k] == hz.ifid_rs1));
      m2 = m2 | (sb_v_q[k] && (sb_rd_q[k] == hz.ifid_rs2));
    end
    m1 = m1 && (hz.ifid_rs1 != '0);
    m2 = m2 && (hz.ifid_rs2 != '0);
    hazard = (hz.ifid_rs1_used & m1) | (hz.ifid_rs2_used & m2);
  end

  always_comb begin
    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.idex_bubble = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.stall       = 1'b0;
    hz.freeze      = 1'b0;
    if (reset) begin
      hz.pc_write = 1'b1;
    end else if (hz.mem_busy) begin
      // A branch during freeze is dropped; EX holds and re-presents it afterwards.
      hz.freeze     = 1'b1;
      hz.pc_write   = 1'b0;
      hz.ifid_write = 1'b0;
    end else if (hz.branch_taken) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
    end else if (hazard) begin
      hz.stall       = 1'b1;
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN, ST_LOAD_STALL, ST_FREEZE: begin
          if (hz.freeze)     state_q <= ST_FREEZE;
          else if (hz.stall) state_q <= ST_LOAD_STALL;
          else               state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign hz.state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] stall_cycles_q, freeze_cycles_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q  <= '0;
      freeze_cycles_q <= '0;
      flush_count_q   <= '0;
    end else begin
      if (hz.stall && stall_cycles_q != CNT_MAX)       stall_cycles_q  <= stall_cycles_q + 1'b1;
      if (hz.freeze && freeze_cycles_q != CNT_MAX)     freeze_cycles_q <= freeze_cycles_q + 1'b1;
      if (hz.ifid_flush && flush_count_q != CNT_MAX)   flush_count_q   <= flush_count_q + 1'b1;
    end
  end

  assign hz.stall_cycles  = stall_cycles_q;
  assign hz.freeze_cycles = freeze_cycles_q;
  assign hz.flush_count   = flush_count_q;
`else
  assign hz.stall_cycles  = '0;
  assign hz.freeze_cycles = '0;
  assign hz.flush_count   = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl at LOAD_LAT 1, 2 and 3
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic rst1, rst2, rst3;
  int   n_assert = 0;
  int   n_fail   = 0;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_AW(5), .CNT_W(16)) b1 ();
  hazard_stall_ctrl_if #(.REG_AW(5), .CNT_W(16)) b2 ();
  hazard_stall_ctrl_if #(.REG_AW(5), .CNT_W(16)) b3 ();

  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u1 (.clk(clk), .reset(rst1), .hz(b1));
  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(16)) u2 (.clk(clk), .reset(rst2), .hz(b2));
  hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u3 (.clk(clk), .reset(rst3), .hz(b3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {b1.ifid_rs1, b1.ifid_rs2, b1.ifid_rs1_used, b1.ifid_rs2_used, b1.idex_rd,
     b1.idex_memread, b1.idex_regwrite, b1.branch_taken, b1.mem_busy} = '0;
    {b2.ifid_rs1, b2.ifid_rs2, b2.ifid_rs1_used, b2.ifid_rs2_used, b2.idex_rd,
     b2.idex_memread, b2.idex_regwrite, b2.branch_taken, b2.mem_busy} = '0;
    {b3.ifid_rs1, b3.ifid_rs2, b3.ifid_rs1_used, b3.ifid_rs2_used, b3.idex_rd,
     b3.idex_memread, b3.idex_regwrite, b3.branch_taken, b3.mem_busy} = '0;
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    tick();
    #1;
    chk("rst_pc_write", b1.pc_write, 1);
    chk("rst_ifid_write", b1.ifid_write, 1);
    chk("rst_bubble", b1.idex_bubble, 0);
    chk("rst_flush", b1.ifid_flush, 0);
    chk("rst_stall", b1.stall, 0);
    chk("rst_freeze", b1.freeze, 0);
    chk("rst_state", b1.state, 0);
    chk("rst_stall_cnt", b1.stall_cycles, 0);
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    tick();
    chk("post_rst_state", b1.state, 0);
    chk("post_rst_pc_write", b1.pc_write, 1);

    // LOAD_LAT=1 classic load-use: lw x5 in EX, rs1=x5 used in ID
    b1.idex_memread = 1; b1.idex_regwrite = 1; b1.idex_rd = 5;
    b1.ifid_rs1 = 5; b1.ifid_rs1_used = 1;
    #1;
    chk("l1_stall", b1.stall, 1);
    chk("l1_pc_write", b1.pc_write, 0);
    chk("l1_ifid_write", b1.ifid_write, 0);
    chk("l1_bubble", b1.idex_bubble, 1);
    tick();
    chk("l1_state_stall", b1.state, 1);
    b1.idex_memread = 0; b1.idex_regwrite = 0; b1.idex_rd = 0;
    #1;
    chk("l1_release_stall", b1.stall, 0);
    chk("l1_release_pc", b1.pc_write, 1);
    tick();
    chk("l1_state_run", b1.state, 0);
    chk("l1_stall_cnt", b1.stall_cycles, PERF ? 1 : 0);

    // Cases that must not stall
    b1.idex_memread = 1; b1.idex_regwrite = 1; b1.idex_rd = 0;
    b1.ifid_rs1 = 0; b1.ifid_rs1_used = 1;
    #1;
    chk("no_stall_rd0", b1.stall, 0);
    b1.idex_rd = 5; b1.ifid_rs1 = 5; b1.ifid_rs1_used = 0;
    #1;
    chk("no_stall_unused", b1.stall, 0);
    chk("no_stall_unused_pc", b1.pc_write, 1);
    b1.ifid_rs1_used = 1; b1.idex_regwrite = 0;
    #1;
    chk("no_stall_noregwrite", b1.stall, 0);
    b1.idex_regwrite = 1; b1.ifid_rs1_used = 0; b1.ifid_rs2 = 5; b1.ifid_rs2_used = 1;
    #1;
    chk("rs2_match_stall", b1.stall, 1);
    b1.ifid_rs1 = 5; b1.ifid_rs1_used = 1;
    #1;
    chk("equal_rs_stall", b1.stall, 1);

    // Branch wins over a simultaneous hazard
    b1.branch_taken = 1;
    #1;
    chk("br_flush", b1.ifid_flush, 1);
    chk("br_bubble", b1.idex_bubble, 1);
    chk("br_stall", b1.stall, 0);
    chk("br_pc_write", b1.pc_write, 1);
    chk("br_ifid_write", b1.ifid_write, 1);
    tick();
    chk("br_state", b1.state, 0);
    chk("br_flush_cnt", b1.flush_count, PERF ? 1 : 0);
    {b1.ifid_rs1_used, b1.ifid_rs2_used, b1.idex_memread, b1.idex_regwrite, b1.branch_taken} = '0;

    // LOAD_LAT=3: load x7 then dependent rs2=x7 stalls three cycles
    b3.idex_memread = 1; b3.idex_regwrite = 1; b3.idex_rd = 7;
    b3.ifid_rs2 = 7; b3.ifid_rs2_used = 1;
    #1;
    chk("l3_stall_c1", b3.stall, 1);
    tick();
    b3.idex_memread = 0; b3.idex_regwrite = 0; b3.idex_rd = 0;
    #1;
    chk("l3_stall_c2", b3.stall, 1);
    chk("l3_state_c2", b3.state, 1);
    tick();
    chk("l3_stall_c3", b3.stall, 1);
    chk("l3_bubble_c3", b3.idex_bubble, 1);
    tick();
    chk("l3_stall_c4", b3.stall, 0);
    chk("l3_pc_c4", b3.pc_write, 1);
    chk("l3_stall_cnt", b3.stall_cycles, PERF ? 3 : 0);
    tick();
    chk("l3_state_run", b3.state, 0);

    // LOAD_LAT=2: freeze for 4 cycles in the middle of the stall
    b2.idex_memread = 1; b2.idex_regwrite = 1; b2.idex_rd = 9;
    b2.ifid_rs1 = 9; b2.ifid_rs1_used = 1;
    #1;
    chk("l2_stall_c1", b2.stall, 1);
    tick();
    b2.idex_memread = 0; b2.idex_regwrite = 0; b2.idex_rd = 0; b2.mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      b2.branch_taken = (i == 1);
      #1;
      chk("fz_freeze", b2.freeze, 1);
      chk("fz_pc_write", b2.pc_write, 0);
      chk("fz_ifid_write", b2.ifid_write, 0);
      chk("fz_bubble", b2.idex_bubble, 0);
      chk("fz_flush", b2.ifid_flush, 0);
      chk("fz_stall", b2.stall, 0);
      tick();
      chk("fz_state", b2.state, 2);
    end
    b2.mem_busy = 0; b2.branch_taken = 0;
    #1;
    chk("l2_resume_stall", b2.stall, 1);
    tick();
    chk("l2_resume_state", b2.state, 1);
    chk("l2_done_stall", b2.stall, 0);
    chk("l2_freeze_cnt", b2.freeze_cycles, PERF ? 4 : 0);
    chk("l2_stall_cnt", b2.stall_cycles, PERF ? 2 : 0);

    // Reset in the second cycle of a LOAD_LAT=3 stall
    b3.idex_memread = 1; b3.idex_regwrite = 1; b3.idex_rd = 7;
    tick();
    b3.idex_memread = 0; b3.idex_regwrite = 0; b3.idex_rd = 0;
    #1;
    chk("rm_stall_before", b3.stall, 1);
    rst3 = 1;
    #1;
    chk("rm_stall_in_reset", b3.stall, 0);
    chk("rm_pc_in_reset", b3.pc_write, 1);
    tick();
    chk("rm_state", b3.state, 0);
    rst3 = 0;
    #1;
    chk("rm_stall_after", b3.stall, 0);
    chk("rm_stall_cnt", b3.stall_cycles, 0);
    tick();
    chk("rm_state_run", b3.state, 0);
    chk("rm_stall_after2", b3.stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
